vx_rr_stream_arbiter: RTL and testbench
=======================================

// Module: vx_rr_stream_arbiter
// PURPOSE
//  N-to-1 round-robin arbiter for valid/ready streams sharing one downstream port.
//  Builds a one-hot grant from the requests and a rotating priority pointer, and
//  selects the winner's payload through a one-hot AND-OR mux. Registers the result in a
//  one-entry elastic output stage. Used wherever several lanes/units contend for one
//  pipeline slot (e.g. issue->dispatch, core->memory request merge).
// PARAMETERS
//  NUM_REQS  4   number of requesters (>=1)
//  DATAW     32  payload width per requester
//  SELW      derived = (NUM_REQS>1) ? $clog2(NUM_REQS) : 1; index width
// PORTS
//  clk        in   1                   clock, all state updates on rising edge
//  reset      in   1                   synchronous, active-high
//  valid_in   in   NUM_REQS            per-requester valid
//  data_in    in   NUM_REQS*DATAW      per-requester payload, [i] = requester i
//  ready_in   out  NUM_REQS            per-requester accept (one-hot or zero)
//  valid_out  out  1                   output stage holds a transfer
//  data_out   out  DATAW               payload of granted requester
//  sel_out    out  SELW                binary index of granted requester
//  ready_out  in   1                   downstream accept
// BEHAVIOUR
//  - Reset (sync, high): valid_out=0, data_out=0, sel_out=0, priority ptr=0
//    (requester 0 highest). Reset mid-transfer drops held entry; ready_in=0 that cycle.
//  - can_accept = !valid_out || ready_out (full-throughput pipe register).
//  - grant: one-hot, first valid_in[i] scanning i = ptr, ptr+1, ... wrapping mod
//    NUM_REQS; all-zero if no valid_in. Combinational from valid_in and ptr only.
//  - ready_in = grant & {NUM_REQS{can_accept}}; never more than one bit set.
//  - fire = |valid_in && can_accept. On fire: data_out <= one-hot mux(data_in, grant),
//    sel_out <= index(grant), valid_out <= 1, ptr <= (index(grant)+1) mod NUM_REQS.
//  - No fire and ready_out=1: valid_out <= 0; data_out/sel_out keep last values.
//  - No fire and ready_out=0: output stage holds; valid_out/data_out/sel_out stable.
//  - ptr changes only on fire (never on stall or idle).
//  - Latency 1 cycle in->out; throughput 1 transfer/cycle with ready_out=1.
//  - Fairness: with all requesters continuously valid, each wins exactly once every
//    NUM_REQS transfers; a waiting requester waits at most NUM_REQS-1 transfers.
//  - Requester valid may drop before grant; arbitration is recomputed each cycle.
//  - Simultaneous drain+fill (valid_out=1, ready_out=1, fire): new entry replaces old
//    in same edge, no bubble.
//  - NUM_REQS==1: grant = valid_in, sel_out constant 0, ptr logic omitted; behaves
//    as a single pipe register.
//  - Wrap: ptr at NUM_REQS-1 winning -> ptr becomes 0.
// TESTING
//  1 Reset: assert reset 2 cycles with all valid_in=1 -> valid_out=0, ready_in=0,
//    sel_out=0; first post-reset grant goes to req 0.
//  2 Round-robin: N=4, valid_in=4'b1111 held, ready_out=1 -> sel_out sequence
//    0,1,2,3,0,1 on consecutive cycles; data_out matches data_in[sel].
//  3 Sparse skip/wrap: ptr=0, valid_in=4'b1010 -> grant req1 then req3, then
//    (valid_in=4'b0001) req0; ptr wraps 3->0 correctly.
//  4 Backpressure: valid_out=1, ready_out=0 for 3 cycles with new requests -> ready_in=0,
//    data_out/sel_out stable, ptr unchanged; ready_out=1 -> drain+fill same cycle.
//  5 Idle drain: single transfer then valid_in=0, ready_out=1 -> valid_out drops next
//    cycle; ptr stays at winner+1.
//  6 Reset mid-operation: reset while valid_out=1, ready_out=0 -> next cycle
//    valid_out=0, ptr=0; held payload never delivered.

Source files
------------

// File: rtl/vx_rr_stream_arbiter.sv
// vx_rr_stream_arbiter: N-to-1 round-robin arbiter for valid/ready streams
// with a one-hot AND-OR payload mux feeding a one-entry elastic output register.
module vx_rr_stream_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 32,
    localparam int SELW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       valid_in,
    input  logic [NUM_REQS*DATAW-1:0] data_in,
    output logic [NUM_REQS-1:0]       ready_in,
    output logic                      valid_out,
    output logic [DATAW-1:0]          data_out,
    output logic [SELW-1:0]           sel_out,
    input  logic                      ready_out
);
    logic [NUM_REQS-1:0] grant;
    logic [SELW-1:0]     idx;
    logic [DATAW-1:0]    mux;
    logic                can_accept;
    logic                fire;

    // ready_in is held low during reset so nothing is consumed on a dropped cycle
    assign can_accept = !reset && (!valid_out || ready_out);
    assign fire       = (|valid_in) && can_accept;
    assign ready_in   = grant & {NUM_REQS{can_accept}};

    generate
        if (NUM_REQS == 1) begin : g_single
            assign grant = valid_in;
            assign idx   = '0;
        end else begin : g_rr
            logic [SELW-1:0] ptr;
            always_comb begin
                grant = '0;
                idx   = '0;
                for (int k = NUM_REQS - 1; k >= 0; k--) begin
                    int j;
                    j = int'(ptr) + k;
                    if (j >= NUM_REQS) j -= NUM_REQS;
                    if (valid_in[j]) begin
                        grant    = '0;
                        grant[j] = 1'b1;
                        idx      = SELW'(j);
                    end
                end
            end
            always_ff @(posedge clk) begin
                if (reset)
                    ptr <= '0;
                else if (fire)
                    ptr <= (idx == SELW'(NUM_REQS - 1)) ? '0 : idx + 1'b1;
            end
        end
    endgenerate

    always_comb begin
        mux = '0;
        for (int i = 0; i < NUM_REQS; i++)
            mux |= data_in[i*DATAW +: DATAW] & {DATAW{grant[i]}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            sel_out   <= '0;
        end else if (fire) begin
            valid_out <= 1'b1;
            data_out  <= mux;
            sel_out   <= idx;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vx_rr_stream_arbiter.sv
// tb_vx_rr_stream_arbiter: directed vector table plus randomized traffic
// compared against a queue-free round-robin reference model.
module tb_vx_rr_stream_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 0;
    logic           reset;
    logic [N-1:0]   valid_in;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   ready_in;
    logic           valid_out;
    logic [W-1:0]   data_out;
    logic [1:0]     sel_out;
    logic           ready_out;

    int checks = 0;
    int errors = 0;

    int          m_ptr;
    logic        m_valid;
    logic [W-1:0] m_data;
    int          m_sel;

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       ro;
        logic [3:0] rdy;
        logic       vo;
        logic [1:0] sel;
    } vec_t;

    vec_t vecs[21];

    vx_rr_stream_arbiter #(.NUM_REQS(N), .DATAW(W)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
        .sel_out(sel_out), .ready_out(ready_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle, checks against the model at negedge, then advances the model.
    task automatic cycle(input logic r, input logic [N-1:0] v, input logic ro, input bit check);
        int w;
        logic can;
        logic [N-1:0] exp_rdy;
        reset = r;
        valid_in = v;
        ready_out = ro;
        for (int i = 0; i < N; i++) data_in[i*W +: W] = $urandom;
        @(negedge clk);
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        can = !r && (!m_valid || ro);
        exp_rdy = (can && w >= 0) ? N'(1 << w) : '0;
        if (check) begin
            chk("model_ready_in", 32'(ready_in), 32'(exp_rdy));
            chk("model_valid_out", 32'(valid_out), 32'(m_valid));
            chk("model_sel_out", 32'(sel_out), 32'(m_sel));
            chk("model_data_out", data_out, m_data);
        end
        if (r) begin
            m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
        end else if (can && w >= 0) begin
            m_valid = 1; m_data = data_in[w*W +: W]; m_sel = w; m_ptr = (w + 1) % N;
        end else if (ro) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1, 4'b1111, 1, 4'b0000, 0, 0};
        vecs[1]  = '{0, 4'b1111, 1, 4'b0001, 0, 0};
        vecs[2]  = '{0, 4'b1111, 1, 4'b0010, 1, 0};
        vecs[3]  = '{0, 4'b1111, 1, 4'b0100, 1, 1};
        vecs[4]  = '{0, 4'b1111, 1, 4'b1000, 1, 2};
        vecs[5]  = '{0, 4'b1111, 1, 4'b0001, 1, 3};
        vecs[6]  = '{1, 4'b1111, 1, 4'b0000, 1, 0};
        vecs[7]  = '{0, 4'b1010, 1, 4'b0010, 0, 0};
        vecs[8]  = '{0, 4'b1010, 1, 4'b1000, 1, 1};
        vecs[9]  = '{0, 4'b0001, 1, 4'b0001, 1, 3};
        vecs[10] = '{0, 4'b1111, 0, 4'b0000, 1, 0};
        vecs[11] = '{0, 4'b1111, 0, 4'b0000, 1, 0};
        vecs[12] = '{0, 4'b1111, 0, 4'b0000, 1, 0};
        vecs[13] = '{0, 4'b1111, 1, 4'b0010, 1, 0};
        vecs[14] = '{0, 4'b0000, 1, 4'b0000, 1, 1};
        vecs[15] = '{0, 4'b0000, 1, 4'b0000, 0, 1};
        vecs[16] = '{0, 4'b1111, 1, 4'b0100, 0, 1};
        vecs[17] = '{0, 4'b0000, 0, 4'b0000, 1, 2};
        vecs[18] = '{1, 4'b1111, 0, 4'b0000, 1, 2};
        vecs[19] = '{0, 4'b1111, 1, 4'b0001, 0, 0};
        vecs[20] = '{0, 4'b0000, 1, 4'b0000, 1, 0};
        m_ptr = 0; m_valid = 0; m_data = '0; m_sel = 0;
        reset = 1; valid_in = '0; data_in = '0; ready_out = 1;
        @(posedge clk);
        #1;
        cycle(1, 4'b1111, 1, 0);
        for (int t = 0; t < 21; t++) begin
            reset = vecs[t].rst;
            valid_in = vecs[t].v;
            ready_out = vecs[t].ro;
            #2;
            chk($sformatf("vec%0d_ready_in", t), 32'(ready_in), 32'(vecs[t].rdy));
            chk($sformatf("vec%0d_valid_out", t), 32'(valid_out), 32'(vecs[t].vo));
            chk($sformatf("vec%0d_sel_out", t), 32'(sel_out), 32'(vecs[t].sel));
            cycle(vecs[t].rst, vecs[t].v, vecs[t].ro, 1);
        end
        for (int t = 0; t < 3000; t++)
            cycle(($urandom_range(0, 99) == 0), N'($urandom), ($urandom_range(0, 3) != 0), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
